// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Operands enter and results leave over valid/ready handshakes.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and the producer holds its data
  // stable while valid is high and ready is low.

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic            carry;
  logic [CW-1:0]   count;
  logic            fa_a;
  logic            fa_b;
  logic            fa_s;
  logic            fa_co;

  // Full-adder cell in sum-of-products form.
  always_comb begin
    fa_a  = a_q[0];
    fa_b  = b_q[0];
    fa_s  = (~fa_a & ~fa_b &  carry) | (~fa_a &  fa_b & ~carry) |
            ( fa_a & ~fa_b & ~carry) | ( fa_a &  fa_b &  carry);
    fa_co = (fa_a & fa_b) | (fa_a & carry) | (fa_b & carry);
  end

  assign in_ready  = (state == IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      count     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            count <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          sum   <= {fa_s, sum[WIDTH-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          carry <= fa_co;
          // Counter is held on the final bit so it never wraps.
          if (count == LAST) begin
            cout      <= fa_co;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 directed table, backpressure, abort and random
// ops, plus an exhaustive sweep of a WIDTH=2 instance.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [7:0] a, b, sum;
  logic [1:0] fsm_state;

  logic       in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2, busy2;
  logic [1:0] a2, b2, sum2;
  logic [1:0] fsm_state2;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [8:0] exp_q[$];

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy), .fsm_state(fsm_state)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2), .busy(busy2), .fsm_state(fsm_state2)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Waits for a result, checks latency, compares against the scoreboard and consumes it.
  task automatic finish_op(input string name, input int exp_lat);
    int cyc;
    logic [8:0] exp;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, cyc, exp_lat);
    exp = exp_q.pop_front();
    check({name, " result"}, {cout, sum}, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Driver: called at a negedge; offers operands until accepted, then waits for the result.
  task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                        input logic [8:0] exp, input logic early_ready, input string name);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    a = oa;
    b = ob;
    cin = oc;
    exp_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    cin = 1'($urandom);
    out_ready = early_ready;
    finish_op(name, 8);
  endtask

  initial begin
    vec_t vecs[8];
    logic [8:0] bp_exp;
    int cyc;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[3] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};

    // Reset with random activity on the inputs
    rst_n = 1'b0;
    out_ready = 1'b0;
    out_ready2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      cin = 1'($urandom);
      in_valid2 = 1'($urandom);
      a2 = 2'($urandom);
      b2 = 2'($urandom);
      cin2 = 1'($urandom);
    end
    @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    check("reset state", fsm_state, 0);
    check("reset2 in_ready", in_ready2, 1);
    check("reset2 out_valid", out_valid2, 0);
    in_valid = 1'b0;
    in_valid2 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table; sum and cout expectations written out by hand
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].exp_cout, vecs[i].exp_sum},
             1'b0, $sformatf("vec%0d", i));

    // Backpressure: result held while new operands are offered and ignored
    in_valid = 1'b1;
    a = 8'h10;
    b = 8'h20;
    cin = 1'b0;
    exp_q.push_back(9'h030);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("bp latency", cyc, 8);
    in_valid = 1'b1;
    a = 8'h77;
    b = 8'h11;
    cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp hold sum", sum, 8'h30);
      check("bp hold cout", cout, 0);
      check("bp in_ready", in_ready, 0);
      check("bp out_valid", out_valid, 1);
    end
    bp_exp = exp_q.pop_front();
    check("bp result", {cout, sum}, bp_exp);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp idle in_ready", in_ready, 1);
    check("bp idle out_valid", out_valid, 0);
    check("bp idle busy", busy, 0);
    out_ready = 1'b0;
    exp_q.push_back(9'h089);
    @(negedge clk);
    check("bp accept busy", busy, 1);
    check("bp accept in_ready", in_ready, 0);
    in_valid = 1'b0;
    finish_op("bp second", 8);

    // Abort: asynchronous reset during the third ADD cycle
    in_valid = 1'b1;
    a = 8'h5A;
    b = 8'h33;
    cin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort pre busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort in_ready", in_ready, 1);
    check("abort out_valid", out_valid, 0);
    check("abort sum", sum, 0);
    check("abort cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'h03, 8'h04, 1'b0, 9'h007, 1'b0, "after abort");

    // Exhaustive WIDTH=2 sweep
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      logic [2:0] exp2;
      v = 5'(i);
      in_valid2 = 1'b1;
      a2 = v[1:0];
      b2 = v[3:2];
      cin2 = v[4];
      exp2 = 3'(v[1:0]) + 3'(v[3:2]) + 3'(v[4]);
      @(negedge clk);
      in_valid2 = 1'b0;
      cyc = 0;
      while (!out_valid2 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      check($sformatf("w2 %0d latency", i), cyc, 2);
      check($sformatf("w2 %0d result", i), {cout2, sum2}, exp2);
      out_ready2 = 1'b1;
      @(negedge clk);
      out_ready2 = 1'b0;
    end

    // Random back-to-back ops, early out_ready sometimes asserted during ADD
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc), 1'($urandom_range(0, 1)),
             $sformatf("rnd%0d", i));
    end

    check("scoreboard empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around one 1-bit full-adder cell (sum/cout in sum-of-products form) plus a registered carry.
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready input handshake.
- Adds LSB-first, one bit per clock.
- Presents the WIDTH-bit sum and carry-out over a valid/ready output handshake.
- Downstream stage that consumes the 1-bit adder's sum/cout each cycle. Trades area for latency in the arithmetic exercises.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a, b, cin valid this cycle.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for bit 0.
- out_valid  output  1  sum/cout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result bits.
- cout  output  1  registered carry-out from bit WIDTH-1.
- busy  output  1  high in ADD or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; A/B shift regs, sum, cout, carry flop, bit counter all 0; in_ready=1; out_valid=0; busy=0.
- Reset asserted mid-operation aborts the add. No partial result is ever presented.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1: load A<=a, B<=b, carry<=cin, count<=0, sum<=0; go to ADD.
  - Otherwise stay in IDLE.
- ADD (in_ready=0, busy=1), each cycle:
  - Full-adder inputs are A[0], B[0], carry.
  - sum shifts right with the FA sum bit entering at bit WIDTH-1.
  - A and B shift right with 0 fill.
  - carry<=FA cout; count<=count+1.
  - On the edge where count==WIDTH-1, also load cout<=FA cout, then go to DONE.
- Latency: if operands are accepted on edge E0, out_valid rises after edge E0+WIDTH. That is exactly WIDTH clocks in ADD.
- DONE (out_valid=1, in_ready=0, busy=1):
  - sum and cout are held stable until an edge with out_ready=1.
  - On that edge: out_valid<=0, go to IDLE.
  - sum/cout keep their last value in IDLE until the next load clears sum.
- Throughput: at most one add per WIDTH+2 cycles. No overlap of input acceptance with an active add.
- in_valid while in_ready=0 is ignored; the operands are not captured.
- out_ready while out_valid=0 is ignored.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1). No saturation.
- Counter width is clog2(WIDTH). The counter never wraps, because it exits at WIDTH-1.
- Outputs are driven from flops only. There is no combinational path from inputs to outputs except in_ready, which is decoded from state.

Test Plan:
- Reset check:
  - Stimulus: hold rst_n=0, toggle clk, drive random a/b/in_valid.
  - Required: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
- Carry ripple (WIDTH=8):
  - Stimulus: a=8'hFF, b=8'h01, cin=0, in_valid pulse.
  - Required: out_valid high exactly 8 clocks after acceptance; sum=8'h00, cout=1.
- Carry-in path:
  - Stimulus: a=8'hA5, b=8'h5A, cin=1.
  - Required: sum=8'h00, cout=1.
  - Stimulus: a=8'h12, b=8'h34, cin=0.
  - Required: sum=8'h46, cout=0.
- Backpressure:
  - Stimulus: complete an add, hold out_ready=0 for 5 cycles while in_valid=1 with new operands.
  - Required: sum/cout unchanged, in_ready=0, new operands not captured. Raise out_ready: IDLE next cycle, then new operands accepted.
- Abort:
  - Stimulus: assert rst_n=0 asynchronously at ADD cycle 3.
  - Required: outputs reset immediately. The next add (a=8'h03, b=8'h04, cin=0) yields sum=8'h07, cout=0.
- Exhaustive (WIDTH=2 and WIDTH=8 random):
  - Stimulus: all 32 combinations of a, b, cin at WIDTH=2; 1000 random back-to-back ops at WIDTH=8.
  - Required: {cout,sum} == a+b+cin in every case.
